// File: rtl/ex_stage_reg.sv
// Execute-stage pipeline register: ALU result plus decode context.
// Define EX_OVERFLOW_TRAP_EN to turn signed ALU overflow into exception 3.
module ex_stage_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] alu_out,
  input  logic        alu_of,
  input  logic [29:0] id_pc,
  input  logic        id_en,
  input  logic        id_br_flag,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] id_mem_wr_data,
  input  logic [1:0]  id_ctrl_op,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic [2:0]  id_exp_code,
  output logic [31:0] fwd_data,
  output logic [29:0] ex_pc,
  output logic        ex_en,
  output logic        ex_br_flag,
  output logic [1:0]  ex_mem_op,
  output logic [31:0] ex_mem_wr_data,
  output logic [1:0]  ex_ctrl_op,
  output logic [4:0]  ex_dst_addr,
  output logic        ex_gpr_we_,
  output logic [2:0]  ex_exp_code,
  output logic [31:0] ex_out
);

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br;
    logic [1:0]  mem_op;
    logic [31:0] wr_data;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  exp;
    logic [31:0] out;
  } ex_t;

  localparam logic [2:0] EXP_OVF = 3'd3;

  localparam ex_t BUBBLE = '{
    pc:      30'd0,
    en:      1'b0,
    br:      1'b0,
    mem_op:  2'd0,
    wr_data: 32'd0,
    ctrl_op: 2'd0,
    dst:     5'd0,
    we_:     1'b1,
    exp:     3'd0,
    out:     32'd0
  };

  ex_t ex_q;
  ex_t ex_d;
  ex_t cap;

  always_comb begin
    cap.pc      = id_pc;
    cap.en      = id_en;
    cap.br      = id_br_flag;
    cap.mem_op  = id_mem_op;
    cap.wr_data = id_mem_wr_data;
    cap.ctrl_op = id_ctrl_op;
    cap.dst     = id_dst_addr;
    cap.we_     = id_gpr_we_;
    cap.exp     = id_exp_code;
    cap.out     = alu_out;
`ifdef EX_OVERFLOW_TRAP_EN
    // Upstream exceptions outrank overflow; bubbles never trap.
    if (id_exp_code == 3'd0 && id_en && alu_of) begin
      cap.exp    = EXP_OVF;
      cap.we_    = 1'b1;
      cap.mem_op = 2'd0;
    end
`endif
  end

`ifndef EX_OVERFLOW_TRAP_EN
  logic unused_alu_of;
  assign unused_alu_of = alu_of;
`endif

  always_comb begin
    ex_d = ex_q;
    if (stall) begin
      ex_d = ex_q;
    end else if (flush) begin
      ex_d = BUBBLE;
    end else begin
      ex_d = cap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign fwd_data       = alu_out;
  assign ex_pc          = ex_q.pc;
  assign ex_en          = ex_q.en;
  assign ex_br_flag     = ex_q.br;
  assign ex_mem_op      = ex_q.mem_op;
  assign ex_mem_wr_data = ex_q.wr_data;
  assign ex_ctrl_op     = ex_q.ctrl_op;
  assign ex_dst_addr    = ex_q.dst;
  assign ex_gpr_we_     = ex_q.we_;
  assign ex_exp_code    = ex_q.exp;
  assign ex_out         = ex_q.out;

endmodule
